// File: rtl/zest_pkg.sv
// Shared constants, saturation helpers and FSM state type for z_state_estimator.
package zest_pkg;

    localparam int DW_DEFAULT = 16;
    localparam logic signed [DW_DEFAULT-1:0] SAT_MAX = {1'b0, {(DW_DEFAULT-1){1'b1}}};
    localparam logic signed [DW_DEFAULT-1:0] SAT_MIN = {1'b1, {(DW_DEFAULT-1){1'b0}}};

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } zest_state_e;

    // Clamp a wide signed value into the range of a w-bit signed word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic is_sat(input logic signed [63:0] v, input int w);
        return sat(v, w) != v;
    endfunction

endpackage

// File: rtl/zest_boxcar.sv
// Boxcar history for z_state_estimator: N-deep circular sample buffer,
// write pointer, saturating fill count and running window sum.
module zest_boxcar #(
    parameter int DW       = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic signed [DW-1:0]         wr_data,
    output logic signed [DW+AVG_LOG2-1:0] sum,
    output logic [AVG_LOG2:0]            fill_cnt
);

    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int          SW = DW + AVG_LOG2;
    localparam int          CW = AVG_LOG2 + 1;

    logic signed [DW-1:0] mem_q [N];
    logic signed [DW-1:0] mem_d [N];
    logic [AVG_LOG2-1:0]  wptr_q, wptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [SW-1:0] sum_q, sum_d;

    // Unwritten slots hold zero, so the oldest-sample subtraction is correct while filling.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        if (clear) begin
            for (int unsigned i = 0; i < N; i++) mem_d[i] = '0;
            wptr_d = '0;
            cnt_d  = '0;
            sum_d  = '0;
        end else if (wr_en) begin
            mem_d[wptr_q] = wr_data;
            sum_d         = sum_q + SW'(wr_data) - SW'(mem_q[wptr_q]);
            wptr_d        = wptr_q + 1'b1;
            cnt_d         = (cnt_q == CW'(N)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
        end
    end

    assign sum      = sum_q;
    assign fill_cnt = cnt_q;

endmodule

// File: rtl/z_state_estimator.sv
// Vertical-position sensor front-end: boxcar average, setpoint subtract, velocity differencer.
// Optional outlier rejection enabled by defining ZEST_OUTLIER_REJECT_EN.
module z_state_estimator
    import zest_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int AVG_LOG2   = 2,
    parameter int VEL_SHIFT  = 0,
    parameter int OUTLIER_TH = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adc_valid,
    input  logic signed [DW-1:0] adc_data,
    input  logic signed [DW-1:0] z_ref,
    input  logic                 clear,
    output logic signed [DW-1:0] z_pos,
    output logic signed [DW-1:0] z_vel,
    output logic                 est_valid,
    output logic                 primed,
    output logic                 sat_event,
    output logic [7:0]           reject_cnt
);

    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int          SW = DW + AVG_LOG2;
    localparam int          CW = AVG_LOG2 + 1;

`ifdef ZEST_OUTLIER_REJECT_EN
    localparam bit OUTLIER_EN = 1'b1;
`else
    localparam bit OUTLIER_EN = 1'b0;
`endif

    zest_state_e          state_q, state_d;
    logic                 accept, reject, nth;
    logic signed [DW-1:0] sample_in;
    logic signed [SW-1:0] sum;
    logic [CW-1:0]        fill_cnt;
    logic signed [63:0]   dev;

    logic                 v1_q, v1_d;
    logic                 first1_q, first1_d;
    logic signed [DW-1:0] zref_q, zref_d;
    logic signed [DW-1:0] last_q, last_d;
    logic [7:0]           rej_q, rej_d;

    logic signed [DW-1:0] avg, pos;
    logic signed [63:0]   pos_raw, vel_raw;
    logic                 pos_clamped, vel_clamped;

    logic signed [DW-1:0] z_pos_q, z_pos_d;
    logic signed [DW-1:0] z_vel_q, z_vel_d;
    logic signed [DW-1:0] pos_prev_q, pos_prev_d;
    logic                 est_q, est_d;
    logic                 sat_q, sat_d;

    zest_boxcar #(
        .DW       (DW),
        .AVG_LOG2 (AVG_LOG2)
    ) u_boxcar (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (accept),
        .wr_data  (sample_in),
        .sum      (sum),
        .fill_cnt (fill_cnt)
    );

    // Stage 1: acceptance, outlier substitution, FSM and setpoint capture.
    always_comb begin
        accept = adc_valid && !clear;
        dev    = 64'(adc_data) - 64'(last_q);
        if (dev < 0) dev = -dev;
        reject    = OUTLIER_EN && accept && (state_q == RUN) && (dev > 64'(OUTLIER_TH));
        sample_in = reject ? last_q : adc_data;
        nth       = accept && (state_q == FILL) && (fill_cnt == CW'(N - 1));

        state_d = state_q;
        if (clear)    state_d = FILL;
        else if (nth) state_d = RUN;

        v1_d     = accept && ((state_q == RUN) || nth);
        first1_d = nth;
        zref_d   = accept ? z_ref : zref_q;
        last_d   = accept ? sample_in : last_q;
        rej_d    = (reject && (rej_q != 8'hFF)) ? rej_q + 8'd1 : rej_q;
    end

    // Stages 2/3: average, position error, velocity and output register update.
    always_comb begin
        avg         = DW'(sum >>> AVG_LOG2);
        pos_raw     = 64'(avg) - 64'(zref_q);
        pos         = DW'(sat(pos_raw, DW));
        pos_clamped = is_sat(pos_raw, DW);
        vel_raw     = first1_q ? 64'sd0 : ((64'(pos) - 64'(pos_prev_q)) <<< VEL_SHIFT);
        vel_clamped = is_sat(vel_raw, DW);

        est_d      = v1_q && !clear;
        z_pos_d    = z_pos_q;
        z_vel_d    = z_vel_q;
        pos_prev_d = pos_prev_q;
        sat_d      = 1'b0;
        if (est_d) begin
            z_pos_d    = pos;
            z_vel_d    = DW'(sat(vel_raw, DW));
            pos_prev_d = pos;
            sat_d      = pos_clamped || vel_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            v1_q       <= 1'b0;
            first1_q   <= 1'b0;
            zref_q     <= '0;
            last_q     <= '0;
            rej_q      <= '0;
            z_pos_q    <= '0;
            z_vel_q    <= '0;
            pos_prev_q <= '0;
            est_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            v1_q       <= v1_d;
            first1_q   <= first1_d;
            zref_q     <= zref_d;
            last_q     <= last_d;
            rej_q      <= rej_d;
            z_pos_q    <= z_pos_d;
            z_vel_q    <= z_vel_d;
            pos_prev_q <= pos_prev_d;
            est_q      <= est_d;
            sat_q      <= sat_d;
        end
    end

    assign z_pos      = z_pos_q;
    assign z_vel      = z_vel_q;
    assign est_valid  = est_q;
    assign sat_event  = sat_q;
    assign primed     = (state_q == RUN);
    assign reject_cnt = rej_q;

endmodule

// File: tb/tb_z_state_estimator.sv
// Self-checking bench for z_state_estimator: directed vector table, hand sequences
// and randomized traffic against a windowed-average reference model.
module tb_z_state_estimator;
    import zest_pkg::*;

    localparam int N  = 4;
    localparam int TH = 1000;
`ifdef ZEST_OUTLIER_REJECT_EN
    localparam bit OUT_EN = 1'b1;
`else
    localparam bit OUT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic adc_valid = 1'b0;
    logic clear = 1'b0;
    logic signed [15:0] adc_data = '0;
    logic signed [15:0] z_ref = '0;
    logic signed [15:0] z_pos, z_vel;
    logic est_valid, primed, sat_event;
    logic [7:0] reject_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    z_state_estimator #(
        .DW         (16),
        .AVG_LOG2   (2),
        .VEL_SHIFT  (0),
        .OUTLIER_TH (TH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .z_ref      (z_ref),
        .clear      (clear),
        .z_pos      (z_pos),
        .z_vel      (z_vel),
        .est_valid  (est_valid),
        .primed     (primed),
        .sat_event  (sat_event),
        .reject_cnt (reject_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int v, input longint d, input longint r, input int c);
        adc_valid = (v != 0);
        adc_data  = 16'(d);
        z_ref     = 16'(r);
        clear     = (c != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        adc_valid = 1'b0;
        clear     = 1'b0;
        adc_data  = '0;
        z_ref     = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: keeps the last N accepted samples and derives each estimate directly.
    typedef struct {
        longint p;
        longint v;
        int     s;
    } est_t;

    est_t   expq[int];
    longint win[$];
    longint m_last, m_prev, h_pos, h_vel;
    int     m_first, m_rej, m_primed, h_sat;

    function automatic longint clampv(input longint x);
        if (x > longint'(SAT_MAX)) return longint'(SAT_MAX);
        if (x < longint'(SAT_MIN)) return longint'(SAT_MIN);
        return x;
    endfunction

    function automatic longint fdiv(input longint s, input longint n);
        longint q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        win.delete();
        expq.delete();
        m_last = 0; m_prev = 0; h_pos = 0; h_vel = 0;
        m_first = 1; m_rej = 0; m_primed = 0; h_sat = 0;
    endtask

    task automatic model_step(input int e, input int v, input longint d, input longint r, input int c);
        longint x, s, raw, p, vraw, vel, dropped;
        est_t   t;
        if (c != 0) begin
            win.delete();
            m_first = 1;
            if (expq.exists(e)) expq.delete(e);
        end else if (v != 0) begin
            x = d;
            if (OUT_EN && (win.size() == N) && ((x > m_last ? x - m_last : m_last - x) > TH)) begin
                x = m_last;
                if (m_rej < 255) m_rej++;
            end
            m_last = x;
            win.push_back(x);
            if (win.size() > N) dropped = win.pop_front();
            if (win.size() == N) begin
                s = 0;
                foreach (win[k]) s += win[k];
                raw  = fdiv(s, N) - r;
                p    = clampv(raw);
                vraw = m_first ? 0 : (p - m_prev);
                vel  = clampv(vraw);
                t.p = p;
                t.v = vel;
                t.s = ((p != raw) || (vel != vraw)) ? 1 : 0;
                expq[e + 1] = t;
                m_prev  = p;
                m_first = 0;
            end
        end
        m_primed = (win.size() == N) ? 1 : 0;
    endtask

    task automatic model_check(input int e);
        if (expq.exists(e)) begin
            chk("rnd_est_valid", est_valid, 1);
            h_pos = expq[e].p;
            h_vel = expq[e].v;
            h_sat = expq[e].s;
            expq.delete(e);
        end else begin
            chk("rnd_est_valid", est_valid, 0);
            h_sat = 0;
        end
        chk("rnd_z_pos", z_pos, h_pos);
        chk("rnd_z_vel", z_vel, h_vel);
        chk("rnd_sat_event", sat_event, h_sat);
        chk("rnd_primed", primed, m_primed);
        chk("rnd_reject_cnt", reject_cnt, m_rej);
    endtask

    typedef struct {
        int v, d, c, est, pos, vel, pr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int     rv, rc;
        longint rd, rr;

        // Fill, ramp, back-to-back estimates, then clear with a simultaneous sample.
        tbl[0]  = '{1, 40, 0, 0,  0,  0, 0};
        tbl[1]  = '{1, 40, 0, 0,  0,  0, 0};
        tbl[2]  = '{1, 40, 0, 0,  0,  0, 0};
        tbl[3]  = '{1, 40, 0, 0,  0,  0, 1};
        tbl[4]  = '{1, 80, 0, 1, 40,  0, 1};
        tbl[5]  = '{1, 80, 0, 1, 50, 10, 1};
        tbl[6]  = '{1, 80, 0, 1, 60, 10, 1};
        tbl[7]  = '{0,  0, 0, 1, 70, 10, 1};
        tbl[8]  = '{0,  0, 0, 0, 70, 10, 1};
        tbl[9]  = '{1, 40, 0, 0, 70, 10, 1};
        tbl[10] = '{1, 40, 1, 0, 70, 10, 0};
        tbl[11] = '{0,  0, 0, 0, 70, 10, 0};
        tbl[12] = '{1, 20, 0, 0, 70, 10, 0};
        tbl[13] = '{1, 20, 0, 0, 70, 10, 0};
        tbl[14] = '{1, 20, 0, 0, 70, 10, 0};
        tbl[15] = '{1, 20, 0, 0, 70, 10, 1};
        tbl[16] = '{0,  0, 0, 1, 20,  0, 1};
        tbl[17] = '{0,  0, 0, 0, 20,  0, 1};

        do_reset();
        chk("reset_est_valid", est_valid, 0);
        chk("reset_z_pos", z_pos, 0);
        chk("reset_z_vel", z_vel, 0);
        chk("reset_primed", primed, 0);
        chk("reset_sat_event", sat_event, 0);
        chk("reset_reject_cnt", reject_cnt, 0);

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].v, tbl[i].d, 0, tbl[i].c);
            chk($sformatf("tbl%0d_est_valid", i), est_valid, tbl[i].est);
            chk($sformatf("tbl%0d_z_pos", i), z_pos, tbl[i].pos);
            chk($sformatf("tbl%0d_z_vel", i), z_vel, tbl[i].vel);
            chk($sformatf("tbl%0d_primed", i), primed, tbl[i].pr);
            chk($sformatf("tbl%0d_sat_event", i), sat_event, 0);
        end

        // Position saturation against an extreme setpoint.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32000, -32768, 0);
        chk("sat_pre_est", est_valid, 0);
        cycle(0, 0, -32768, 0);
        chk("sat_est_valid", est_valid, 1);
        chk("sat_z_pos", z_pos, 32767);
        chk("sat_z_vel", z_vel, 0);
        chk("sat_event", sat_event, 1);
        cycle(0, 0, 0, 0);
        chk("sat_event_pulse", sat_event, 0);

        // Outlier after priming on a flat signal.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 100, 0, 0);
        cycle(1, 5000, 0, 0);
        chk("outl_first_pos", z_pos, 100);
        cycle(0, 0, 0, 0);
        chk("outl_est_valid", est_valid, 1);
        chk("outl_z_pos", z_pos, OUT_EN ? 100 : 1325);
        chk("outl_z_vel", z_vel, OUT_EN ? 0 : 1225);
        chk("outl_reject_cnt", reject_cnt, OUT_EN ? 1 : 0);

        // Asynchronous reset in the middle of a sample stream.
        cycle(1, 300, 0, 0);
        cycle(1, 300, 0, 0);
        adc_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_est_valid", est_valid, 0);
        chk("arst_z_pos", z_pos, 0);
        chk("arst_z_vel", z_vel, 0);
        chk("arst_primed", primed, 0);
        chk("arst_sat_event", sat_event, 0);
        chk("arst_reject_cnt", reject_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            chk("arst_no_est", est_valid, 0);
            chk("arst_hold_pos", z_pos, 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int e = 0; e < 1200; e++) begin
            rv = ($urandom_range(0, 9) < 7) ? 1 : 0;
            rc = ($urandom_range(0, 39) == 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) rd = longint'(int'($urandom_range(0, 65535)) - 32768);
            else                           rd = longint'(int'($urandom_range(0, 2400)) - 1200);
            if ($urandom_range(0, 9) == 0) rr = longint'(int'($urandom_range(0, 65535)) - 32768);
            else                           rr = longint'(int'($urandom_range(0, 1000)) - 500);
            model_step(e, rv, rd, rr, rc);
            cycle(rv, rd, rr, rc);
            model_check(e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
